romulus_ctr_lfsr: RTL and testbench

Romulus 56-bit block-counter LFSR plus 8-bit domain-separation byte; produces the 64-bit tweakey-counter word loaded into the 32-bit-datapath TK counter register. It sits directly upstream of that register. It drives both the forward value (`tkz_ctr`) and the revert value (`tkz_revert`) that the register reloads between SKINNY invocations. Counter stepping uses a valid/ready handshake with the mode controller. Wrap-around is detected and reported.

---
 rtl/romulus_ctr_lfsr_pkg.sv | 45 ++++
 rtl/romulus_ctr_lfsr_if.sv | 34 +++
 rtl/romulus_ctr_lfsr_snap.sv | 69 ++++++
 rtl/romulus_ctr_lfsr.sv | 117 +++++++++++
 tb/tb_romulus_ctr_lfsr.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/romulus_ctr_lfsr_pkg.sv
// ----------------------------------------------------------------------------
// romulus_pkg
//   Shared constants, types and helpers for the Romulus block-counter path.
//   - CTR_W / DOM_W / TKZ_W : counter, domain byte and tweakey word widths
//   - LFSR_FB               : Galois feedback taps of x^56+x^7+x^4+x^2+1
//   - CTR_ONE               : counter start value (also the wrap marker)
//   - snap_state_e          : snapshot FSM states
//   - lfsr56_step()         : one Galois LFSR step
//   - pack_tkz()            : byte-reversed counter + domain byte packing
// ----------------------------------------------------------------------------
package romulus_pkg;

  localparam int CTR_W = 56;
  localparam int DOM_W = 8;
  localparam int TKZ_W = 64;

  localparam logic [7:0]       LFSR_FB = 8'h95;
  localparam logic [CTR_W-1:0] CTR_ONE = 56'h1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SNAP = 1'b1
  } snap_state_e;

  // Shift left; when the MSB falls out, fold the tap pattern into the low byte.
  function automatic logic [CTR_W-1:0] lfsr56_step(input logic [CTR_W-1:0] c);
    logic [CTR_W-1:0] fb;
    fb = c[CTR_W-1] ? {{(CTR_W-8){1'b0}}, LFSR_FB} : '0;
    return {c[CTR_W-2:0], 1'b0} ^ fb;
  endfunction

  // Counter bytes are emitted least-significant first from the top of the
  // word downwards; the domain byte occupies the bottom byte.
  function automatic logic [TKZ_W-1:0] pack_tkz(input logic [CTR_W-1:0] ctr,
                                                input logic [DOM_W-1:0] dom);
    logic [TKZ_W-1:0] w;
    w = '0;
    for (int i = 0; i < CTR_W / 8; i++) begin
      w[TKZ_W-1-8*i -: 8] = ctr[8*i +: 8];
    end
    w[DOM_W-1:0] = dom;
    return w;
  endfunction

endpackage

// File: rtl/romulus_ctr_lfsr_if.sv
// ----------------------------------------------------------------------------
// romulus_ctr_lfsr_if
//   Bundle between the mode controller (master) and the counter (slave).
//   master drives : init, ld_en, ld_val, dom_we, dom_in, inc_valid, save,
//                   restore
//   slave drives  : inc_ready, tkz_ctr, tkz_revert, ovf
// ----------------------------------------------------------------------------
interface romulus_ctr_lfsr_if;
  import romulus_pkg::*;

  logic             init;
  logic             ld_en;
  logic [CTR_W-1:0] ld_val;
  logic             dom_we;
  logic [DOM_W-1:0] dom_in;
  logic             inc_valid;
  logic             inc_ready;
  logic             save;
  logic             restore;
  logic [TKZ_W-1:0] tkz_ctr;
  logic [TKZ_W-1:0] tkz_revert;
  logic             ovf;

  modport master (
    output init, ld_en, ld_val, dom_we, dom_in, inc_valid, save, restore,
    input  inc_ready, tkz_ctr, tkz_revert, ovf
  );

  modport slave (
    input  init, ld_en, ld_val, dom_we, dom_in, inc_valid, save, restore,
    output inc_ready, tkz_ctr, tkz_revert, ovf
  );

endinterface

// File: rtl/romulus_ctr_lfsr_snap.sv
// ----------------------------------------------------------------------------
// romulus_ctr_snap
//   Snapshot register for the counter/domain pair plus its IDLE/SNAP FSM.
//   IDLE means no valid snapshot is held. A restore never changes the state
//   (SNAP stays SNAP, IDLE ignores it), so restore is not an input here; the
//   parent gates restore with snap_vld.
//   Ports:
//     clk, rst          : clock, asynchronous active-low reset
//     init              : invalidate snapshot (already gated by parent)
//     save              : capture cur_ctr/cur_dom (pre-update values)
//     cur_ctr, cur_dom  : live counter register and domain register
//     snap_vld          : snapshot holds a saved value (state == SNAP)
//     snap_ctr, snap_dom: saved values
// ----------------------------------------------------------------------------
module romulus_ctr_snap
  import romulus_pkg::*;
#(
  parameter logic [DOM_W-1:0] DOMAIN_RST = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             save,
  input  logic [CTR_W-1:0] cur_ctr,
  input  logic [DOM_W-1:0] cur_dom,
  output logic             snap_vld,
  output logic [CTR_W-1:0] snap_ctr,
  output logic [DOM_W-1:0] snap_dom
);

  snap_state_e      state_q;
  logic [CTR_W-1:0] snap_ctr_q;
  logic [DOM_W-1:0] snap_dom_q;

  // Snapshot data is reset too so that the revert word matches the live word
  // straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      snap_ctr_q <= CTR_ONE;
      snap_dom_q <= DOMAIN_RST;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!init && save) begin
            state_q    <= ST_SNAP;
            snap_ctr_q <= cur_ctr;
            snap_dom_q <= cur_dom;
          end
        end
        ST_SNAP: begin
          // init wins over a same-cycle save: the snapshot is invalidated.
          if (init) begin
            state_q <= ST_IDLE;
          end else if (save) begin
            snap_ctr_q <= cur_ctr;
            snap_dom_q <= cur_dom;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign snap_vld = (state_q == ST_SNAP);
  assign snap_ctr = snap_ctr_q;
  assign snap_dom = snap_dom_q;

endmodule

// File: rtl/romulus_ctr_lfsr.sv
// ----------------------------------------------------------------------------
// romulus_ctr_lfsr
//   56-bit Galois LFSR block counter plus 8-bit domain byte, packed into the
//   64-bit tweakey-counter word (live value and revert value).
//   Build option: define ROMULUS_CTR_SNAPSHOT_EN to include the snapshot
//   register and IDLE/SNAP FSM (save/restore active). Without it, tkz_revert
//   mirrors tkz_ctr and save/restore are ignored.
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous active-low reset
//     bus  : romulus_ctr_lfsr_if.slave (load, init, domain write, step
//            handshake, save/restore, tkz_ctr, tkz_revert, ovf)
//   Parameter:
//     DOMAIN_RST : reset value of the domain byte
// ----------------------------------------------------------------------------
module romulus_ctr_lfsr
  import romulus_pkg::*;
#(
  parameter logic [DOM_W-1:0] DOMAIN_RST = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  romulus_ctr_lfsr_if.slave    bus
);

  logic [CTR_W-1:0] ctr_q, ctr_d, ctr_step;
  logic [DOM_W-1:0] dom_q, dom_d;
  logic             ovf_q, ovf_d;

  logic             init_eff;
  logic             step_fire;
  logic             restore_eff;
  logic             restore_win;
  logic             snap_vld;
  logic [CTR_W-1:0] snap_ctr;
  logic [DOM_W-1:0] snap_dom;

  // A load drops a same-cycle init entirely, including its ovf/snapshot side
  // effects, so that ld_en never disturbs ovf or the snapshot.
  assign init_eff  = bus.init & ~bus.ld_en;
  assign step_fire = bus.inc_valid & ~ovf_q;
  assign ctr_step  = lfsr56_step(ctr_q);

`ifdef ROMULUS_CTR_SNAPSHOT_EN
  romulus_ctr_snap #(
    .DOMAIN_RST (DOMAIN_RST)
  ) u_snap (
    .clk      (clk),
    .rst      (rst),
    .init     (init_eff),
    .save     (bus.save),
    .cur_ctr  (ctr_q),
    .cur_dom  (dom_q),
    .snap_vld (snap_vld),
    .snap_ctr (snap_ctr),
    .snap_dom (snap_dom)
  );

  // restore with no valid snapshot is not a request at all, so it does not
  // block a lower-priority step.
  assign restore_eff    = bus.restore & snap_vld;
  assign bus.tkz_revert = pack_tkz(snap_ctr, snap_dom);
`else
  assign snap_vld       = 1'b0;
  assign snap_ctr       = CTR_ONE;
  assign snap_dom       = DOMAIN_RST;
  assign restore_eff    = 1'b0;
  assign bus.tkz_revert = bus.tkz_ctr;
`endif

  // restore that lost to ld_en/init is dropped for the domain byte as well.
  assign restore_win = restore_eff & ~bus.ld_en & ~bus.init;

  always_comb begin
    ctr_d = ctr_q;
    ovf_d = ovf_q;
    dom_d = dom_q;

    if (bus.ld_en) begin
      ctr_d = bus.ld_val;
    end else if (bus.init) begin
      ctr_d = CTR_ONE;
      ovf_d = 1'b0;
    end else if (restore_eff) begin
      ctr_d = snap_ctr;
    end else if (step_fire) begin
      ctr_d = ctr_step;
      // Returning to 1 means the full 2^56-1 period has been consumed.
      if (ctr_step == CTR_ONE) begin
        ovf_d = 1'b1;
      end
    end

    if (restore_win) begin
      dom_d = snap_dom;
    end else if (bus.dom_we) begin
      dom_d = bus.dom_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctr_q <= CTR_ONE;
      dom_q <= DOMAIN_RST;
      ovf_q <= 1'b0;
    end else begin
      ctr_q <= ctr_d;
      dom_q <= dom_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.tkz_ctr   = pack_tkz(ctr_q, dom_q);
  assign bus.inc_ready = ~ovf_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_romulus_ctr_lfsr.sv
module tb_romulus_ctr_lfsr;

`ifdef ROMULUS_CTR_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  localparam logic [63:0] C1 = 64'h0100_0000_0000_0000;

  typedef struct {
    int          cyc;
    string       nm;
    logic [63:0] c;
    logic [63:0] r;
    logic        o;
    logic        rd;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   fails;
  exp_t q[$];
  exp_t mon_e;

  romulus_ctr_lfsr_if bus ();

  romulus_ctr_lfsr #(.DOMAIN_RST(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: compares every expectation due in the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      tests++;
      if (mon_e.cyc != cyc || bus.tkz_ctr !== mon_e.c || bus.tkz_revert !== mon_e.r ||
          bus.ovf !== mon_e.o || bus.inc_ready !== mon_e.rd) begin
        fails++;
        $display("FAIL %s: got ctr=%h rev=%h ovf=%b rdy=%b, expected ctr=%h rev=%h ovf=%b rdy=%b (cyc %0d/%0d)",
                 mon_e.nm, bus.tkz_ctr, bus.tkz_revert, bus.ovf, bus.inc_ready,
                 mon_e.c, mon_e.r, mon_e.o, mon_e.rd, cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] rv(input logic [63:0] snapv, input logic [63:0] live);
    return SNAP ? snapv : live;
  endfunction

  task automatic push(input string nm, input logic [63:0] c, input logic [63:0] r,
                      input logic o, input logic rd, input int dly);
    exp_t e;
    e.cyc = cyc + dly;
    e.nm  = nm;
    e.c   = c;
    e.r   = r;
    e.o   = o;
    e.rd  = rd;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    cyc = 0;
    tests = 0;
    fails = 0;
    bus.init = 1'b0;
    bus.ld_en = 1'b0;
    bus.ld_val = '0;
    bus.dom_we = 1'b0;
    bus.dom_in = '0;
    bus.inc_valid = 1'b0;
    bus.save = 1'b0;
    bus.restore = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    push("reset_vals", C1, C1, 1'b0, 1'b1, 0);
    rst = 1'b1;
    tick();

    // Three plain steps from reset
    bus.inc_valid = 1'b1;
    push("step1", 64'h0200_0000_0000_0000, rv(C1, 64'h0200_0000_0000_0000), 1'b0, 1'b1, 1);
    tick();
    push("step2", 64'h0400_0000_0000_0000, rv(C1, 64'h0400_0000_0000_0000), 1'b0, 1'b1, 1);
    tick();
    push("step3", 64'h0800_0000_0000_0000, rv(C1, 64'h0800_0000_0000_0000), 1'b0, 1'b1, 1);
    tick();
    bus.inc_valid = 1'b0;

    // MSB set: step folds in the feedback taps
    bus.ld_en = 1'b1;
    bus.ld_val = 56'h80_0000_0000_0000;
    push("ld_msb", 64'h0000_0000_0000_8000, rv(C1, 64'h0000_0000_0000_8000), 1'b0, 1'b1, 1);
    tick();
    bus.ld_en = 1'b0;
    bus.inc_valid = 1'b1;
    push("step_fb", 64'h9500_0000_0000_0000, rv(C1, 64'h9500_0000_0000_0000), 1'b0, 1'b1, 1);
    tick();
    bus.inc_valid = 1'b0;

    // Wrap to 1 sets ovf, blocks further steps, init clears it
    bus.ld_en = 1'b1;
    bus.ld_val = 56'h80_0000_0000_004A;
    push("ld_wrap", 64'h4A00_0000_0000_8000, rv(C1, 64'h4A00_0000_0000_8000), 1'b0, 1'b1, 1);
    tick();
    bus.ld_en = 1'b0;
    bus.inc_valid = 1'b1;
    push("wrap_ovf", C1, C1, 1'b1, 1'b0, 1);
    tick();
    push("ovf_hold1", C1, C1, 1'b1, 1'b0, 1);
    tick();
    push("ovf_hold2", C1, C1, 1'b1, 1'b0, 1);
    tick();
    bus.inc_valid = 1'b0;
    bus.init = 1'b1;
    push("init_clr", C1, C1, 1'b0, 1'b1, 1);
    tick();
    bus.init = 1'b0;

    // Save at c=4, two steps, restore
    bus.inc_valid = 1'b1;
    push("to_c2", 64'h0200_0000_0000_0000, rv(C1, 64'h0200_0000_0000_0000), 1'b0, 1'b1, 1);
    tick();
    push("to_c4", 64'h0400_0000_0000_0000, rv(C1, 64'h0400_0000_0000_0000), 1'b0, 1'b1, 1);
    tick();
    bus.inc_valid = 1'b0;
    bus.save = 1'b1;
    push("save_c4", 64'h0400_0000_0000_0000, 64'h0400_0000_0000_0000, 1'b0, 1'b1, 1);
    tick();
    bus.save = 1'b0;
    bus.inc_valid = 1'b1;
    push("to_c8", 64'h0800_0000_0000_0000,
         rv(64'h0400_0000_0000_0000, 64'h0800_0000_0000_0000), 1'b0, 1'b1, 1);
    tick();
    push("to_c16", 64'h1000_0000_0000_0000,
         rv(64'h0400_0000_0000_0000, 64'h1000_0000_0000_0000), 1'b0, 1'b1, 1);
    tick();
    bus.inc_valid = 1'b0;
    bus.restore = 1'b1;
    push("restore_c4", rv(64'h0400_0000_0000_0000, 64'h1000_0000_0000_0000),
         rv(64'h0400_0000_0000_0000, 64'h1000_0000_0000_0000), 1'b0, 1'b1, 1);
    tick();
    bus.restore = 1'b0;

    // Save concurrent with a step captures the pre-step value
    bus.init = 1'b1;
    push("init2", C1, rv(64'h0400_0000_0000_0000, C1), 1'b0, 1'b1, 1);
    tick();
    bus.init = 1'b0;
    bus.inc_valid = 1'b1;
    push("step_c2", 64'h0200_0000_0000_0000,
         rv(64'h0400_0000_0000_0000, 64'h0200_0000_0000_0000), 1'b0, 1'b1, 1);
    tick();
    bus.save = 1'b1;
    push("save_step", 64'h0400_0000_0000_0000,
         rv(64'h0200_0000_0000_0000, 64'h0400_0000_0000_0000), 1'b0, 1'b1, 1);
    tick();
    bus.save = 1'b0;
    bus.inc_valid = 1'b0;

    // Load beats step and restore; snapshot untouched
    bus.ld_en = 1'b1;
    bus.ld_val = 56'h7;
    bus.inc_valid = 1'b1;
    bus.restore = 1'b1;
    push("ld_prio", 64'h0700_0000_0000_0000,
         rv(64'h0200_0000_0000_0000, 64'h0700_0000_0000_0000), 1'b0, 1'b1, 1);
    tick();
    bus.ld_en = 1'b0;
    bus.inc_valid = 1'b0;
    push("restore_c2", rv(64'h0200_0000_0000_0000, 64'h0700_0000_0000_0000),
         rv(64'h0200_0000_0000_0000, 64'h0700_0000_0000_0000), 1'b0, 1'b1, 1);
    tick();
    bus.restore = 1'b0;

    // Domain write survives init
    bus.dom_we = 1'b1;
    bus.dom_in = 8'h5A;
    push("dom_we", rv(64'h0200_0000_0000_005A, 64'h0700_0000_0000_005A),
         rv(64'h0200_0000_0000_0000, 64'h0700_0000_0000_005A), 1'b0, 1'b1, 1);
    tick();
    bus.dom_we = 1'b0;
    bus.init = 1'b1;
    push("init_dom", 64'h0100_0000_0000_005A,
         rv(64'h0200_0000_0000_0000, 64'h0100_0000_0000_005A), 1'b0, 1'b1, 1);
    tick();
    bus.init = 1'b0;

    // Restore with no snapshot is ignored, so the step goes through
    bus.restore = 1'b1;
    bus.inc_valid = 1'b1;
    push("restore_idle", 64'h0200_0000_0000_005A,
         rv(64'h0200_0000_0000_0000, 64'h0200_0000_0000_005A), 1'b0, 1'b1, 1);
    tick();
    bus.restore = 1'b0;
    bus.inc_valid = 1'b0;

    // Save, then asynchronous reset mid-stream
    bus.save = 1'b1;
    push("save3", 64'h0200_0000_0000_005A, 64'h0200_0000_0000_005A, 1'b0, 1'b1, 1);
    tick();
    bus.save = 1'b0;
    tick();
    bus.inc_valid = 1'b1;
    rst = 1'b0;
    push("async_rst", C1, C1, 1'b0, 1'b1, 0);
    tick();
    push("rst_hold", C1, C1, 1'b0, 1'b1, 0);
    tick();
    rst = 1'b1;
    bus.inc_valid = 1'b0;

    repeat (3) tick();
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations pending, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
